// File: rtl/dot_product_acc_if.sv
// rtl/dot_product_acc_if.sv - beat-in / group-result-out handshake bundle for dot_product_acc
`timescale 1ns/1ps
interface dot_product_acc_if #(
  parameter int IN_SIZE_0  = 4,
  parameter int IN_SIZE_1  = 8,
  parameter int ARRAY_SIZE = 8,
  parameter int ACC_SIZE   = 32
);
  logic                                 in_valid_i;
  logic                                 in_ready_o;
  logic                                 in_last_i;
  logic                                 signed_0_i;
  logic                                 signed_1_i;
  logic [ARRAY_SIZE-1:0][IN_SIZE_0-1:0] in_0_i;
  logic [ARRAY_SIZE-1:0][IN_SIZE_1-1:0] in_1_i;
  logic                                 out_valid_o;
  logic                                 out_ready_i;
  logic [ACC_SIZE-1:0]                  out_o;
  logic                                 out_ovf_o;

  modport slave (
    input  in_valid_i, in_last_i, signed_0_i, signed_1_i, in_0_i, in_1_i, out_ready_i,
    output in_ready_o, out_valid_o, out_o, out_ovf_o
  );

  modport master (
    output in_valid_i, in_last_i, signed_0_i, signed_1_i, in_0_i, in_1_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_o, out_ovf_o
  );
endinterface

// File: rtl/dot_product_acc.sv
// rtl/dot_product_acc.sv - pipelined signed/unsigned dot-product MAC with per-group accumulation
// Optional feature macro: ACC_SATURATE_EN (clamp the accumulator on overflow instead of wrapping).
`timescale 1ns/1ps
module dot_product_acc #(
  parameter int IN_SIZE_0  = 4,
  parameter int IN_SIZE_1  = 8,
  parameter int ARRAY_SIZE = 8,
  parameter int ACC_SIZE   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  dot_product_acc_if.slave  bus
);
  localparam int PROD_SIZE = IN_SIZE_0 + IN_SIZE_1 + 2;
  localparam int DOT_SIZE  = PROD_SIZE + $clog2(ARRAY_SIZE);

  logic stall, in_ready_c, accept;

  // S0: captured operands
  logic                                 v0_q, last0_q, sg0_q, sg1_q;
  logic [ARRAY_SIZE-1:0][IN_SIZE_0-1:0] a_q;
  logic [ARRAY_SIZE-1:0][IN_SIZE_1-1:0] b_q;
  // S1: lane products
  logic                                 v1_q, last1_q;
  logic [ARRAY_SIZE-1:0][PROD_SIZE-1:0] prod_c, prod1_q;
  // S2: exact lane sum
  logic                                 v2_q, last2_q;
  logic signed [DOT_SIZE-1:0]           dot_c, dot2_q;
  // S3: accumulator and result
  logic signed [ACC_SIZE-1:0]           acc_q, dot_ext, sum_c, acc_next;
  logic                                 ovf_q, ovf_c;
  logic [ACC_SIZE-1:0]                  out_q;
  logic                                 out_valid_q, out_ovf_q;

  assign stall      = out_valid_q && !bus.out_ready_i;
  assign in_ready_c = !stall && !rst_i;
  assign accept     = bus.in_valid_i && in_ready_c;

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic signed [PROD_SIZE-1:0] ea, eb;
    assign ea = PROD_SIZE'($signed({sg0_q & a_q[i][IN_SIZE_0-1], a_q[i]}));
    assign eb = PROD_SIZE'($signed({sg1_q & b_q[i][IN_SIZE_1-1], b_q[i]}));
    assign prod_c[i] = ea * eb;
  end

  always_comb begin
    dot_c = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      dot_c = dot_c + DOT_SIZE'($signed(prod1_q[i]));
    end
  end

  // Signed overflow: operands agree in sign but the sum does not.
  assign dot_ext = ACC_SIZE'(dot2_q);
  assign sum_c   = acc_q + dot_ext;
  assign ovf_c   = (acc_q[ACC_SIZE-1] == dot_ext[ACC_SIZE-1]) &&
                   (sum_c[ACC_SIZE-1] != acc_q[ACC_SIZE-1]);

`ifdef ACC_SATURATE_EN
  assign acc_next = !ovf_c ? sum_c :
                    acc_q[ACC_SIZE-1] ? {1'b1, {(ACC_SIZE-1){1'b0}}}
                                      : {1'b0, {(ACC_SIZE-1){1'b1}}};
`else
  assign acc_next = sum_c;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v0_q <= 1'b0; last0_q <= 1'b0; sg0_q <= 1'b0; sg1_q <= 1'b0;
      a_q <= '0; b_q <= '0;
      v1_q <= 1'b0; last1_q <= 1'b0; prod1_q <= '0;
      v2_q <= 1'b0; last2_q <= 1'b0; dot2_q <= '0;
      acc_q <= '0; ovf_q <= 1'b0;
      out_q <= '0; out_valid_q <= 1'b0; out_ovf_q <= 1'b0;
    end else if (!stall) begin
      v0_q    <= accept;
      last0_q <= bus.in_last_i;
      sg0_q   <= bus.signed_0_i;
      sg1_q   <= bus.signed_1_i;
      a_q     <= bus.in_0_i;
      b_q     <= bus.in_1_i;

      v1_q    <= v0_q;
      last1_q <= v0_q & last0_q;
      prod1_q <= prod_c;

      v2_q    <= v1_q;
      last2_q <= last1_q;
      dot2_q  <= dot_c;

      // Not stalled means any held result is being consumed this cycle.
      out_valid_q <= v2_q && last2_q;
      if (v2_q) begin
        if (last2_q) begin
          out_q     <= acc_next;
          out_ovf_q <= ovf_q | ovf_c;
          acc_q     <= '0;
          ovf_q     <= 1'b0;
        end else begin
          acc_q <= acc_next;
          ovf_q <= ovf_q | ovf_c;
        end
      end
    end
  end

  assign bus.in_ready_o  = in_ready_c;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_o       = out_q;
  assign bus.out_ovf_o   = out_ovf_q;
endmodule

// File: tb/tb_dot_product_acc.sv
// tb/tb_dot_product_acc.sv - directed and randomized bench for dot_product_acc against an arithmetic model
`timescale 1ns/1ps
module tb_dot_product_acc;
  localparam int IN0 = 4, IN1 = 8, AS = 8, ACC = 32;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;
  localparam longint MODV = 64'sd4294967296;

  typedef logic [AS-1:0][IN0-1:0] vec0_t;
  typedef logic [AS-1:0][IN1-1:0] vec1_t;
  typedef struct { longint val; bit ovf; } res_t;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  dot_product_acc_if #(.IN_SIZE_0(IN0), .IN_SIZE_1(IN1), .ARRAY_SIZE(AS), .ACC_SIZE(ACC)) m_if ();
  dot_product_acc #(.IN_SIZE_0(IN0), .IN_SIZE_1(IN1), .ARRAY_SIZE(AS), .ACC_SIZE(ACC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(m_if.slave));

  dot_product_acc_if #(.IN_SIZE_0(7), .IN_SIZE_1(6), .ARRAY_SIZE(2), .ACC_SIZE(16)) s_if ();
  dot_product_acc #(.IN_SIZE_0(7), .IN_SIZE_1(6), .ARRAY_SIZE(2), .ACC_SIZE(16)) dut_s (
    .clk_i(clk_i), .rst_i(rst_i), .bus(s_if.slave));

  int n_checks = 0, n_errors = 0;
  int n_results = 0, cyc = 0, accept_cyc = 0;
  bit rand_bp = 0;
  res_t exp_q[$];
  longint got_q[$];
  longint last_val;
  bit last_ovf;
  res_t mon_e;
  longint m_acc = 0;
  bit m_ovf = 0;

  task automatic check(string tag, longint obs, longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint beat_dot(bit s0, bit s1, vec0_t a, vec1_t b);
    longint d = 0, x, y;
    for (int i = 0; i < AS; i++) begin
      x = longint'(a[i]);
      if (s0 && a[i][IN0-1]) x -= (64'sd1 << IN0);
      y = longint'(b[i]);
      if (s1 && b[i][IN1-1]) y -= (64'sd1 << IN1);
      d += x * y;
    end
    return d;
  endfunction

  function automatic void model_beat(bit last, longint d);
    longint t = m_acc + d;
    bit o = (t > MAXV) || (t < MINV);
`ifdef ACC_SATURATE_EN
    if (t > MAXV) t = MAXV;
    else if (t < MINV) t = MINV;
`else
    if (t > MAXV) t -= MODV;
    else if (t < MINV) t += MODV;
`endif
    if (last) begin
      exp_q.push_back('{val: t, ovf: m_ovf | o});
      m_acc = 0;
      m_ovf = 0;
    end else begin
      m_acc = t;
      m_ovf = m_ovf | o;
    end
  endfunction

  function automatic vec0_t fill0(logic [IN0-1:0] v);
    vec0_t r;
    for (int i = 0; i < AS; i++) r[i] = v;
    return r;
  endfunction

  function automatic vec1_t fill1(logic [IN1-1:0] v);
    vec1_t r;
    for (int i = 0; i < AS; i++) r[i] = v;
    return r;
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (!rst_i && m_if.out_valid_o && m_if.out_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_o", longint'($signed(m_if.out_o)), mon_e.val);
        check("out_ovf_o", longint'(m_if.out_ovf_o), longint'(mon_e.ovf));
      end
      last_val = longint'($signed(m_if.out_o));
      last_ovf = m_if.out_ovf_o;
      got_q.push_back(last_val);
      n_results++;
    end
  end

  always @(posedge clk_i) begin
    if (rand_bp) begin
      #1;
      m_if.out_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(bit last, bit s0, bit s1, vec0_t a, vec1_t b);
    bit ok = 0;
    m_if.in_valid_i = 1'b1;
    m_if.in_last_i  = last;
    m_if.signed_0_i = s0;
    m_if.signed_1_i = s1;
    m_if.in_0_i     = a;
    m_if.in_1_i     = b;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk_i);
      if (m_if.in_ready_o) ok = 1;
      @(posedge clk_i);
      #1;
    end
    if (!ok) check("accept_timeout", 0, 1);
    else begin
      accept_cyc = cyc;
      model_beat(last, beat_dot(s0, s1, a, b));
    end
    m_if.in_valid_i = 1'b0;
  endtask

  task automatic wait_results(int target);
    int k = 0;
    while (n_results < target && k < 300) begin
      @(posedge clk_i);
      #1;
      k++;
    end
    check("result_timeout", longint'(n_results >= target), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, c0;
    vec0_t ra;
    vec1_t rb;
    rst_i = 1'b1;
    m_if.in_valid_i = 0; m_if.in_last_i = 0; m_if.signed_0_i = 0; m_if.signed_1_i = 0;
    m_if.in_0_i = '0; m_if.in_1_i = '0; m_if.out_ready_i = 1;
    s_if.in_valid_i = 0; s_if.in_last_i = 0; s_if.signed_0_i = 0; s_if.signed_1_i = 0;
    s_if.in_0_i = '0; s_if.in_1_i = '0; s_if.out_ready_i = 1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_in_ready", longint'(m_if.in_ready_o), 0);
    check("rst_out_valid", longint'(m_if.out_valid_o), 0);
    check("rst_out", longint'(m_if.out_o), 0);
    check("rst_ovf", longint'(m_if.out_ovf_o), 0);
    @(posedge clk_i); #1; rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_in_ready", longint'(m_if.in_ready_o), 1);
    @(posedge clk_i); #1;

    // single beat, latency exactly three edges
    send(1, 1, 1, fill0(4'd7), fill1(8'd127));
    check("lat_0", longint'(m_if.out_valid_o), 0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk_i); #1;
      check($sformatf("lat_%0d", k), longint'(m_if.out_valid_o), longint'(k == 3));
    end
    wait_results(1);
    check("t1_val", last_val, 7112);
    check("t1_ovf", longint'(last_ovf), 0);

    // four-beat group of signed minimums
    r0 = n_results;
    for (int k = 0; k < 4; k++) send(k == 3, 1, 1, fill0(4'h8), fill1(8'h80));
    wait_results(r0 + 1);
    repeat (5) @(posedge clk_i); #1;
    check("t2_one_pulse", longint'(n_results), longint'(r0 + 1));
    check("t2_val", last_val, 32768);

    // mode switch, back-to-back groups
    got_q.delete();
    r0 = n_results;
    send(1, 0, 0, fill0(4'hF), fill1(8'hFF));
    c0 = accept_cyc;
    send(1, 1, 1, fill0(4'hF), fill1(8'hFF));
    check("t3_no_bubble", longint'(accept_cyc - c0), 1);
    wait_results(r0 + 2);
    check("t3_unsigned", got_q[0], 30600);
    check("t3_signed", got_q[1], 8);

    // backpressure
    got_q.delete();
    r0 = n_results;
    m_if.out_ready_i = 0;
    send(1, 1, 1, fill0(4'd1), fill1(8'd1));
    send(1, 1, 1, fill0(4'd2), fill1(8'd1));
    send(1, 1, 1, fill0(4'd3), fill1(8'd1));
    for (int k = 0; k < 20 && !m_if.out_valid_o; k++) begin @(posedge clk_i); #1; end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      check("bp_in_ready", longint'(m_if.in_ready_o), 0);
    end
    @(posedge clk_i); #1;
    m_if.out_ready_i = 1;
    wait_results(r0 + 3);
    check("t4_count", longint'(got_q.size()), 3);
    if (got_q.size() == 3) begin
      check("t4_r0", got_q[0], 8);
      check("t4_r1", got_q[1], 16);
      check("t4_r2", got_q[2], 24);
    end

    // overflow on the 16-bit accumulator instance: each beat sums to 8192
    s_if.in_0_i = {7'd127, 7'd126};
    s_if.in_1_i = {6'd2, 6'd63};
    s_if.in_valid_i = 1;
    for (int k = 1; k <= 5; k++) begin
      s_if.in_last_i = (k == 5);
      @(negedge clk_i);
      check("t5_ready", longint'(s_if.in_ready_o), 1);
      @(posedge clk_i); #1;
    end
    s_if.in_valid_i = 0;
    for (int k = 0; k < 10 && !s_if.out_valid_o; k++) begin @(posedge clk_i); #1; end
    check("t5_valid", longint'(s_if.out_valid_o), 1);
`ifdef ACC_SATURATE_EN
    check("t5_val", longint'($signed(s_if.out_o)), 32767);
`else
    check("t5_val", longint'($signed(s_if.out_o)), -24576);
`endif
    check("t5_ovf", longint'(s_if.out_ovf_o), 1);

    // reset mid-group
    repeat (3) @(posedge clk_i); #1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < AS; i++) begin ra[i] = IN0'($urandom); rb[i] = IN1'($urandom); end
      send(0, 1, 1, ra, rb);
    end
    rst_i = 1;
    @(posedge clk_i); #1;
    rst_i = 0;
    m_acc = 0; m_ovf = 0;
    exp_q.delete();
    r0 = n_results;
    send(1, 1, 1, fill0(4'd1), fill1(8'd1));
    wait_results(r0 + 1);
    check("t6_val", last_val, 8);
    check("t6_ovf", longint'(last_ovf), 0);

    // randomized groups, modes and backpressure
    rand_bp = 1;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < AS; i++) begin ra[i] = IN0'($urandom); rb[i] = IN1'($urandom); end
      send(($urandom_range(0, 3) == 0) || (k == 299), 1'($urandom), 1'($urandom), ra, rb);
    end
    rand_bp = 0;
    @(posedge clk_i); #2;
    m_if.out_ready_i = 1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin @(posedge clk_i); #1; end
    check("drain_empty", longint'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
